// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  // Sequencer control state.
  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seqState_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_STEP     = 4;

  // Number of low address bits that are zero for a STEP-aligned address.
  function automatic int stepBits(input int step);
    return (step <= 1) ? 0 : $clog2(step);
  endfunction

  localparam int DEFAULT_STEP_BITS = stepBits(DEFAULT_STEP);

endpackage

// File: rtl/pc_seq_unit_ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; a pop while empty leaves the stack untouched. A replace rewrites
// the top entry, or behaves as a push when the stack is empty. The caller
// asserts at most one of push/pop/replace per cycle.
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4,
  localparam int PTR_W    = $clog2(RAS_DEPTH),
  localparam int LVL_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              replace,
  input  logic [ADDR_W-1:0] pushData,
  output logic [ADDR_W-1:0] topData,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  topPtr;
  logic [LVL_W-1:0]  level;
  logic              writeNew;

  assign topPtr   = wrPtr - PTR_W'(1);
  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(RAS_DEPTH));
  assign topData  = mem[topPtr];
  assign writeNew = push | (replace & empty);

  // Entry storage: new entries go to the write pointer, replace rewrites the top.
  // NOTE: the entry array carries no reset; the level counter alone decides
  // which entries are valid, so clearing the storage would only cost flops.
  always_ff @(posedge clk) begin
    if (writeNew) begin
      mem[wrPtr] <= pushData;
    end else if (replace) begin
      mem[topPtr] <= pushData;
    end
  end

  // Pointer, fill level and sticky overflow/underflow flags.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (writeNew) begin
      wrPtr <= wrPtr + PTR_W'(1);
      if (full) begin
        ovf <= 1'b1;
      end else begin
        level <= level + LVL_W'(1);
      end
      if (replace) begin
        unf <= 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        wrPtr <= topPtr;
        level <= level - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: PC register with sequential, branch, jump-register,
// call and return sources, a return-address stack, halt/resume control and a
// retired-instruction counter. Drives the instruction-memory fetch address.
module pc_seq_unit
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                STEP      = DEFAULT_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                RAS_DEPTH = 4,
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              call,
  input  logic              jr_valid,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              ret,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_seq_pc,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int                ALIGN_BITS = stepBits(STEP);
  localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

  seqState_e         state;
  seqState_e         nextState;
  logic [ADDR_W-1:0] pcNext;
  logic [ADDR_W-1:0] brAligned;
  logic [ADDR_W-1:0] jrAligned;
  logic [ADDR_W-1:0] rasTop;
  logic              countInc;
  logic              rasPush;
  logic              rasPop;
  logic              rasReplace;

  assign next_seq_pc = pc + STEP_INC;
  assign brAligned   = br_target & ALIGN_MASK;
  assign jrAligned   = jr_target & ALIGN_MASK;

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rasPush),
    .pop      (rasPop),
    .replace  (rasReplace),
    .pushData (next_seq_pc),
    .topData  (rasTop),
    .empty    (ras_empty),
    .full     (ras_full),
    .ovf      (ras_ovf),
    .unf      (ras_unf)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: halt enters HALTED, resume leaves it; stall freezes both.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    if (!stall) begin
      case (state)
        RUN:     if (halt)   nextState = HALTED;
        HALTED:  if (resume) nextState = RUN;
        default: nextState = RUN;
      endcase
    end
  end

  // Output logic: halt indicator.
  always_comb begin
    halted = (state == HALTED);
  end

  // Next-PC selection, stack operations and count enable by source priority.
  always_comb begin
    pcNext     = pc;
    countInc   = 1'b0;
    rasPush    = 1'b0;
    rasPop     = 1'b0;
    rasReplace = 1'b0;
    if (!stall) begin
      case (state)
        RUN: begin
          if (!halt) begin
            countInc = 1'b1;
            if (ret) begin
              if (call) begin
                // Tail call: return to top, top becomes the new link.
                rasReplace = 1'b1;
                pcNext     = ras_empty ? brAligned : rasTop;
              end else begin
                rasPop = 1'b1;
                pcNext = ras_empty ? next_seq_pc : rasTop;
              end
            end else if (jr_valid) begin
              pcNext = jrAligned;
            end else if (call) begin
              rasPush = 1'b1;
              pcNext  = brAligned;
            end else if (br_taken) begin
              pcNext = brAligned;
            end else begin
              pcNext = next_seq_pc;
            end
          end
        end
        HALTED: begin
          if (resume) begin
            countInc = 1'b1;
            pcNext   = next_seq_pc;
          end
        end
        default: pcNext = pc;
      endcase
    end
  end

  // PC register and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr_count <= '0;
    end else begin
      pc <= pcNext;
      if (countInc) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed self-checking bench for pc_seq_unit: a vector table for the
// single-cycle behaviour plus hand-written multi-cycle sequences.
module tb_pc_seq_unit;

  logic        clk;
  logic        rstN;
  logic        stall, brTaken, call, jrValid, ret, halt, resume;
  logic [31:0] brTarget, jrTarget;
  wire  [31:0] pc, nextSeqPc, instrCount;
  wire         halted, rasEmpty, rasFull, rasOvf, rasUnf;

  // Narrow-address instance for wrap-around checks; controls tied idle.
  logic        rst8N;
  logic        zero1 = 1'b0;
  logic [7:0]  zero8 = 8'h00;
  wire  [7:0]  pc8, nextSeqPc8, instrCount8;
  wire         halted8, rasEmpty8, rasFull8, rasOvf8, rasUnf8;

  int checks = 0;
  int errors = 0;

  pc_seq_unit #(
    .ADDR_W(32), .STEP(4), .RESET_PC(32'h0), .RAS_DEPTH(4), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rstN), .stall(stall), .br_taken(brTaken),
    .br_target(brTarget), .call(call), .jr_valid(jrValid),
    .jr_target(jrTarget), .ret(ret), .halt(halt), .resume(resume),
    .pc(pc), .next_seq_pc(nextSeqPc), .halted(halted),
    .ras_empty(rasEmpty), .ras_full(rasFull), .ras_ovf(rasOvf),
    .ras_unf(rasUnf), .instr_count(instrCount)
  );

  pc_seq_unit #(
    .ADDR_W(8), .STEP(4), .RESET_PC(8'hF8), .RAS_DEPTH(2), .CNT_W(8)
  ) dut8 (
    .clk(clk), .rst_n(rst8N), .stall(zero1), .br_taken(zero1),
    .br_target(zero8), .call(zero1), .jr_valid(zero1),
    .jr_target(zero8), .ret(zero1), .halt(zero1), .resume(zero1),
    .pc(pc8), .next_seq_pc(nextSeqPc8), .halted(halted8),
    .ras_empty(rasEmpty8), .ras_full(rasFull8), .ras_ovf(rasOvf8),
    .ras_unf(rasUnf8), .instr_count(instrCount8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall, brTaken, call, jrValid, ret, halt, resume;
    logic [31:0] brTarget, jrTarget;
    logic [31:0] expPc;
    logic        expHalted, expEmpty;
    logic [31:0] expCount;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic st, br, input logic [31:0] bt,
                              input logic cl, jr, input logic [31:0] jt,
                              input logic rt, hl, rs,
                              input logic [31:0] ePc, input logic eH, eE,
                              input logic [31:0] eC);
    vec_t v;
    v.stall = st; v.brTaken = br; v.brTarget = bt; v.call = cl;
    v.jrValid = jr; v.jrTarget = jt; v.ret = rt; v.halt = hl; v.resume = rs;
    v.expPc = ePc; v.expHalted = eH; v.expEmpty = eE; v.expCount = eC;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; brTaken = 0; call = 0; jrValid = 0; ret = 0; halt = 0; resume = 0;
    brTarget = '0; jrTarget = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    rstN  = 0;
    rst8N = 0;
    #12;
    check("reset pc", pc, 32'h0);
    check("reset halted", halted, 1'b0);
    check("reset empty", rasEmpty, 1'b1);
    check("reset full", rasFull, 1'b0);
    check("reset ovf", rasOvf, 1'b0);
    check("reset unf", rasUnf, 1'b0);
    check("reset count", instrCount, 32'd0);
    check("reset next_seq_pc", nextSeqPc, 32'h4);
    rstN = 1;

    //               st br brT        cl jr jrT        rt hl rs  pc          H  E  cnt
    vecs[0]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 32'h4,    0, 1, 1);
    vecs[1]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 32'h8,    0, 1, 2);
    vecs[2]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 32'hC,    0, 1, 3);
    vecs[3]  = mk(0, 1, 32'h22,   0, 0, 32'h0,    0, 0, 0, 32'h20,   0, 1, 4);
    vecs[4]  = mk(0, 1, 32'h103,  0, 0, 32'h0,    0, 0, 0, 32'h100,  0, 1, 5);
    vecs[5]  = mk(1, 1, 32'h500,  0, 0, 32'h0,    0, 0, 0, 32'h100,  0, 1, 5);
    vecs[6]  = mk(1, 0, 32'h0,    0, 0, 32'h0,    0, 1, 0, 32'h100,  0, 1, 5);
    vecs[7]  = mk(0, 1, 32'h40,   0, 0, 32'h0,    0, 0, 0, 32'h40,   0, 1, 6);
    vecs[8]  = mk(0, 0, 32'h200,  1, 0, 32'h0,    0, 0, 0, 32'h200,  0, 0, 7);
    vecs[9]  = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 32'h204,  0, 0, 8);
    vecs[10] = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 32'h208,  0, 0, 9);
    vecs[11] = mk(0, 0, 32'h0,    0, 0, 32'h0,    1, 0, 0, 32'h44,   0, 1, 10);
    vecs[12] = mk(0, 0, 32'h0,    0, 1, 32'h7F,   0, 0, 0, 32'h7C,   0, 1, 11);
    vecs[13] = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 0, 32'h80,   0, 1, 12);
    vecs[14] = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 1, 0, 32'h80,   1, 1, 12);
    vecs[15] = mk(0, 1, 32'h300,  0, 0, 32'h0,    0, 0, 0, 32'h80,   1, 1, 12);
    vecs[16] = mk(0, 1, 32'h300,  0, 0, 32'h0,    0, 1, 0, 32'h80,   1, 1, 12);
    vecs[17] = mk(1, 0, 32'h0,    0, 0, 32'h0,    0, 0, 1, 32'h80,   1, 1, 12);
    vecs[18] = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 1, 1, 32'h84,   0, 1, 13);
    vecs[19] = mk(0, 1, 32'h2000, 1, 1, 32'h1000, 0, 0, 0, 32'h1000, 0, 1, 14);
    vecs[20] = mk(0, 1, 32'h3000, 1, 0, 32'h0,    0, 0, 0, 32'h3000, 0, 0, 15);
    vecs[21] = mk(0, 0, 32'h0,    0, 1, 32'h6000, 1, 0, 0, 32'h1004, 0, 1, 16);
    vecs[22] = mk(0, 0, 32'h0,    0, 0, 32'h0,    1, 1, 0, 32'h1004, 1, 1, 16);
    vecs[23] = mk(0, 0, 32'h0,    0, 0, 32'h0,    0, 0, 1, 32'h1008, 0, 1, 17);

    for (int i = 0; i < 24; i++) begin
      stall = vecs[i].stall; brTaken = vecs[i].brTaken; brTarget = vecs[i].brTarget;
      call = vecs[i].call; jrValid = vecs[i].jrValid; jrTarget = vecs[i].jrTarget;
      ret = vecs[i].ret; halt = vecs[i].halt; resume = vecs[i].resume;
      tick();
      check($sformatf("vec%0d pc", i), pc, vecs[i].expPc);
      check($sformatf("vec%0d halted", i), halted, vecs[i].expHalted);
      check($sformatf("vec%0d empty", i), rasEmpty, vecs[i].expEmpty);
      check($sformatf("vec%0d count", i), instrCount, vecs[i].expCount);
      check($sformatf("vec%0d ovf", i), rasOvf, 1'b0);
      check($sformatf("vec%0d unf", i), rasUnf, 1'b0);
    end
    idle();

    // Five nested calls into a four-entry stack, then five returns.
    for (int i = 0; i < 5; i++) begin
      call = 1; brTarget = 32'h2000 + 32'h100 * i;
      tick();
      check($sformatf("nest call%0d pc", i), pc, 32'h2000 + 32'h100 * i);
      if (i == 3) begin
        check("nest full after 4 calls", rasFull, 1'b1);
        check("nest ovf before 5th call", rasOvf, 1'b0);
      end
    end
    idle();
    check("nest ovf", rasOvf, 1'b1);
    check("nest full after 5 calls", rasFull, 1'b1);
    check("nest count", instrCount, 32'd22);
    for (int k = 0; k < 4; k++) begin
      ret = 1;
      tick();
      check($sformatf("nest ret%0d pc", k), pc, 32'h2000 + 32'h100 * (3 - k) + 32'h4);
    end
    check("nest empty after 4 rets", rasEmpty, 1'b1);
    check("nest unf before 5th ret", rasUnf, 1'b0);
    tick();
    idle();
    check("nest 5th ret pc", pc, 32'h2008);
    check("nest unf", rasUnf, 1'b1);
    check("nest count after rets", instrCount, 32'd27);

    // Return combined with call while the stack holds an entry.
    call = 1; brTarget = 32'h3000;
    tick();
    check("tail call pc", pc, 32'h3000);
    ret = 1; brTarget = 32'h3400;
    tick();
    check("ret+call pc", pc, 32'h200C);
    check("ret+call empty", rasEmpty, 1'b0);
    idle();
    ret = 1;
    tick();
    idle();
    check("ret after replace pc", pc, 32'h3004);
    check("ret after replace empty", rasEmpty, 1'b1);
    check("ret after replace count", instrCount, 32'd30);

    // Halt, then reset asynchronously in the middle of a cycle.
    halt = 1;
    tick();
    idle();
    check("pre-reset halted", halted, 1'b1);
    #2;
    rstN = 0;
    #1;
    check("async reset pc", pc, 32'h0);
    check("async reset halted", halted, 1'b0);
    check("async reset count", instrCount, 32'd0);
    check("async reset ovf", rasOvf, 1'b0);
    check("async reset unf", rasUnf, 1'b0);
    check("async reset empty", rasEmpty, 1'b1);
    rstN = 1;

    // Return combined with call on an empty stack.
    ret = 1; call = 1; brTarget = 32'h503;
    tick();
    idle();
    check("empty ret+call pc", pc, 32'h500);
    check("empty ret+call unf", rasUnf, 1'b1);
    check("empty ret+call empty", rasEmpty, 1'b0);
    check("empty ret+call count", instrCount, 32'd1);
    ret = 1;
    tick();
    idle();
    check("empty ret+call link", pc, 32'h4);
    check("empty ret+call final empty", rasEmpty, 1'b1);

    // 8-bit address wrap-around and asynchronous reset.
    rst8N = 1;
    tick();
    check("w8 pc FC", pc8, 8'hFC);
    check("w8 next_seq_pc wraps", nextSeqPc8, 8'h00);
    tick();
    check("w8 pc wraps to 0", pc8, 8'h00);
    check("w8 count", instrCount8, 8'd2);
    #2;
    rst8N = 0;
    #1;
    check("w8 async reset pc", pc8, 8'hF8);
    check("w8 async reset count", instrCount8, 8'd0);
    check("w8 async reset halted", halted8, 1'b0);
    rst8N = 1;
    tick();
    check("w8 restart pc", pc8, 8'hFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
